// File: rtl/mac4_operand_feeder.sv
`default_nettype none
// =============================================================================
// mac4_operand_feeder : 4x4 A/B operand store with a row-major issue sequencer
// Rev 1.0
// =============================================================================
module mac4_operand_feeder #(
   parameter int DATA_W = 8
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     ce,
   input  logic                     wr_en,
   input  logic                     wr_sel,
   input  logic [1:0]               wr_row,
   input  logic [1:0]               wr_col,
   input  logic signed [DATA_W-1:0] wr_data,
   input  logic                     start,
   output logic                     busy,
   output logic                     done,
   output logic                     valid_out,
   output logic signed [DATA_W-1:0] a0,
   output logic signed [DATA_W-1:0] a1,
   output logic signed [DATA_W-1:0] a2,
   output logic signed [DATA_W-1:0] a3,
   output logic signed [DATA_W-1:0] b0,
   output logic signed [DATA_W-1:0] b1,
   output logic signed [DATA_W-1:0] b2,
   output logic signed [DATA_W-1:0] b3,
   output logic [1:0]               idx_i,
   output logic [1:0]               idx_j
);

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_RUN  = 2'd1;
   localparam logic [1:0] S_FIN  = 2'd2;

   logic [1:0]        state_q, state_d;
   logic [3:0]        cnt_q;
   logic              busy_w;
   logic [DATA_W-1:0] a_mem_q [4][4];
   logic [DATA_W-1:0] b_mem_q [4][4];

   logic              valid_q, done_q;
   logic [DATA_W-1:0] a0_q, a1_q, a2_q, a3_q;
   logic [DATA_W-1:0] b0_q, b1_q, b2_q, b3_q;
   logic [1:0]        idx_i_q, idx_j_q;

   // Store writes bypass ce but are locked out while a sequence is running.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 4; c++) begin
               a_mem_q[r][c] <= '0;
               b_mem_q[r][c] <= '0;
            end
         end
      end else if (wr_en && !busy_w) begin
         if (wr_sel) b_mem_q[wr_row][wr_col] <= wr_data;
         else        a_mem_q[wr_row][wr_col] <= wr_data;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n)  state_q <= S_IDLE;
      else if (ce) state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE:  if (start) state_d = S_RUN;
         S_RUN:   if (cnt_q == 4'hF) state_d = S_FIN;
         S_FIN:   state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   always_comb begin
      busy_w = (state_q != S_IDLE);
   end

   // cnt_q = {i, j}; a plain 4-bit increment gives row-major order and the wrap.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         cnt_q <= 4'd0;
      end else if (ce) begin
         if (state_q == S_RUN) cnt_q <= cnt_q + 4'd1;
         else                  cnt_q <= 4'd0;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         valid_q <= 1'b0;
         done_q  <= 1'b0;
         a0_q    <= '0;
         a1_q    <= '0;
         a2_q    <= '0;
         a3_q    <= '0;
         b0_q    <= '0;
         b1_q    <= '0;
         b2_q    <= '0;
         b3_q    <= '0;
         idx_i_q <= 2'd0;
         idx_j_q <= 2'd0;
      end else if (ce) begin
         done_q  <= 1'b0;
         valid_q <= 1'b0;
         if (state_q == S_RUN) begin
            valid_q <= 1'b1;
            a0_q    <= a_mem_q[cnt_q[3:2]][0];
            a1_q    <= a_mem_q[cnt_q[3:2]][1];
            a2_q    <= a_mem_q[cnt_q[3:2]][2];
            a3_q    <= a_mem_q[cnt_q[3:2]][3];
            b0_q    <= b_mem_q[0][cnt_q[1:0]];
            b1_q    <= b_mem_q[1][cnt_q[1:0]];
            b2_q    <= b_mem_q[2][cnt_q[1:0]];
            b3_q    <= b_mem_q[3][cnt_q[1:0]];
            idx_i_q <= cnt_q[3:2];
            idx_j_q <= cnt_q[1:0];
         end else if (state_q == S_FIN) begin
            done_q  <= 1'b1;
         end
      end
   end

   assign busy      = busy_w;
   assign done      = done_q;
   assign valid_out = valid_q;
   assign a0        = a0_q;
   assign a1        = a1_q;
   assign a2        = a2_q;
   assign a3        = a3_q;
   assign b0        = b0_q;
   assign b1        = b1_q;
   assign b2        = b2_q;
   assign b3        = b3_q;
   assign idx_i     = idx_i_q;
   assign idx_j     = idx_j_q;

endmodule
`default_nettype wire

// File: tb/tb_mac4_operand_feeder.sv
`default_nettype none
// =============================================================================
// tb_mac4_operand_feeder : randomized self-checking bench against a matrix model
// Rev 1.0
// =============================================================================
module tb_mac4_operand_feeder;

   localparam int DW = 8;
   localparam int VW = 4 + 8*DW;

   logic                 clk = 1'b0;
   logic                 rst_n = 1'b0;
   logic                 ce = 1'b0;
   logic                 wr_en = 1'b0;
   logic                 wr_sel = 1'b0;
   logic [1:0]           wr_row = 2'd0;
   logic [1:0]           wr_col = 2'd0;
   logic signed [DW-1:0] wr_data = '0;
   logic                 start = 1'b0;
   logic                 busy, done, valid_out;
   logic signed [DW-1:0] a0, a1, a2, a3, b0, b1, b2, b3;
   logic [1:0]           idx_i, idx_j;
   logic [VW-1:0]        act_vec;

   int n_total = 0;
   int n_pass  = 0;

   logic signed [DW-1:0] ma [4][4];
   logic signed [DW-1:0] mb [4][4];
   logic [VW-1:0]        cap_vec [$];
   int                   cap_dot [$];

   mac4_operand_feeder #(.DATA_W(DW)) dut (
      .clk(clk), .rst_n(rst_n), .ce(ce), .wr_en(wr_en), .wr_sel(wr_sel),
      .wr_row(wr_row), .wr_col(wr_col), .wr_data(wr_data), .start(start),
      .busy(busy), .done(done), .valid_out(valid_out),
      .a0(a0), .a1(a1), .a2(a2), .a3(a3), .b0(b0), .b1(b1), .b2(b2), .b3(b3),
      .idx_i(idx_i), .idx_j(idx_j)
   );

   always #5 clk = ~clk;

   assign act_vec = {idx_i, idx_j, a0, a1, a2, a3, b0, b1, b2, b3};

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Beat n carries row n/4 of A and column n%4 of B.
   function automatic logic [VW-1:0] exp_vec(input int n);
      int i;
      int j;
      i = n / 4;
      j = n % 4;
      return {2'(i), 2'(j), ma[i][0], ma[i][1], ma[i][2], ma[i][3],
              mb[0][j], mb[1][j], mb[2][j], mb[3][j]};
   endfunction

   task automatic clear_model();
      for (int r = 0; r < 4; r++)
         for (int c = 0; c < 4; c++) begin
            ma[r][c] = '0;
            mb[r][c] = '0;
         end
   endtask

   task automatic write_elem(input bit sel, input int r, input int c, input logic signed [DW-1:0] d);
      ce      = 1'($urandom_range(0, 1));
      wr_en   = 1'b1;
      wr_sel  = sel;
      wr_row  = 2'(r);
      wr_col  = 2'(c);
      wr_data = d;
      tick();
      wr_en = 1'b0;
      if (sel) mb[r][c] = d;
      else     ma[r][c] = d;
   endtask

   task automatic run_seq(input bit toggle, input bit poke, input bit wr_with_start);
      int beats = 0;
      int dones = 0;
      int cyc   = 0;
      bit poked = 0;
      bit ce_used;
      logic [VW-1:0] prev;
      logic prev_valid, prev_done;
      cap_vec.delete();
      cap_dot.delete();
      if (wr_with_start) begin
         wr_en   = 1'b1;
         wr_sel  = 1'b1;
         wr_row  = 2'd3;
         wr_col  = 2'd3;
         wr_data = DW'($urandom);
         mb[3][3] = wr_data;
      end
      start = 1'b1;
      ce    = 1'b1;
      tick();
      start = 1'b0;
      wr_en = 1'b0;
      n_total++;
      if (busy !== 1'b1 || valid_out !== 1'b0)
         $display("FAIL start_edge: busy=%b valid=%b, required busy=1 valid=0", busy, valid_out);
      else n_pass++;
      prev = act_vec; prev_valid = valid_out; prev_done = done;
      while (dones == 0 && cyc < 200) begin
         ce = toggle ? 1'(cyc % 2) : 1'b1;
         if (poke && beats == 3 && !poked) begin
            wr_en = 1'b1; wr_sel = 1'b0; wr_row = 2'd0; wr_col = 2'd0; wr_data = 8'sd5;
            start = 1'b1;
            poked = 1;
         end
         ce_used = ce;
         tick();
         wr_en = 1'b0;
         start = 1'b0;
         cyc++;
         if (!ce_used) begin
            n_total++;
            if ({act_vec, valid_out, done} !== {prev, prev_valid, prev_done})
               $display("FAIL ce_hold: got %h/%b/%b, required %h/%b/%b", act_vec, valid_out, done, prev, prev_valid, prev_done);
            else n_pass++;
         end else if (valid_out === 1'b1) begin
            if (!toggle && beats == 0) begin
               n_total++;
               if (cyc != 1) $display("FAIL first_beat_latency: cycle %0d, required 1", cyc);
               else n_pass++;
            end
            n_total++;
            if (act_vec !== exp_vec(beats))
               $display("FAIL beat%0d: got %h, required %h", beats, act_vec, exp_vec(beats));
            else n_pass++;
            cap_vec.push_back(act_vec);
            cap_dot.push_back(int'(a0)*int'(b0) + int'(a1)*int'(b1) + int'(a2)*int'(b2) + int'(a3)*int'(b3));
            beats++;
         end else begin
            n_total++;
            if (done !== 1'b1 || beats != 16 || prev_valid !== 1'b1)
               $display("FAIL seq_end: done=%b beats=%0d prev_valid=%b, required 1/16/1", done, beats, prev_valid);
            else n_pass++;
            if (done === 1'b1) dones++;
         end
         prev = act_vec; prev_valid = valid_out; prev_done = done;
      end
      n_total++;
      if (dones != 1 || beats != 16) $display("FAIL seq_count: dones=%0d beats=%0d, required 1/16", dones, beats);
      else n_pass++;
      ce = 1'b1;
      tick();
      n_total++;
      if ({done, busy, valid_out} !== 3'b000)
         $display("FAIL after_done: done/busy/valid=%b%b%b, required 000", done, busy, valid_out);
      else n_pass++;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      ce    = 1'b0;
      tick();
      tick();
      n_total++;
      if ({busy, done, valid_out, act_vec} !== '0)
         $display("FAIL reset_state: got %b%b%b %h, required all zero", busy, done, valid_out, act_vec);
      else n_pass++;
      rst_n = 1'b1;
      clear_model();
   endtask

   task automatic test_identity();
      logic [VW-1:0] v;
      for (int r = 0; r < 4; r++)
         for (int c = 0; c < 4; c++) begin
            write_elem(0, r, c, (r == c) ? 8'sd1 : 8'sd0);
            write_elem(1, r, c, DW'(4*r + c));
         end
      run_seq(0, 0, 0);
      v = (cap_vec.size() > 6) ? cap_vec[6] : '0;
      n_total++;
      if (v !== {2'd1, 2'd2, 8'd0, 8'd1, 8'd0, 8'd0, 8'd2, 8'd6, 8'd10, 8'd14})
         $display("FAIL identity_beat_1_2: got %h, required a=(0,1,0,0) b=(2,6,10,14)", v);
      else n_pass++;
   endtask

   task automatic test_signs();
      logic [VW-1:0] v;
      logic [4*DW-1:0] a_part;
      write_elem(0, 0, 0, -8'sd128);
      write_elem(0, 0, 1, 8'sd127);
      write_elem(0, 0, 2, -8'sd1);
      write_elem(0, 0, 3, 8'sd0);
      run_seq(0, 0, 0);
      v = (cap_vec.size() > 0) ? cap_vec[0] : '0;
      a_part = v[8*DW-1 -: 4*DW];
      n_total++;
      if (a_part !== 32'h807FFF00) $display("FAIL sign_bits: a=%h, required 807fff00", a_part);
      else n_pass++;
   endtask

   task automatic test_ce_toggle();
      run_seq(1, 0, 0);
   endtask

   task automatic test_busy_ignore();
      bit seen = 0;
      run_seq(0, 1, 0);
      for (int c = 0; c < 6; c++) begin
         tick();
         if (valid_out !== 1'b0 || busy !== 1'b0) seen = 1;
      end
      n_total++;
      if (seen) $display("FAIL busy_ignore_second_seq: activity seen=%0d, required 0", seen);
      else n_pass++;
      run_seq(0, 0, 0);
   endtask

   task automatic test_reset_mid();
      bit hit = 0;
      bit seen = 0;
      start = 1'b1;
      ce    = 1'b1;
      tick();
      start = 1'b0;
      for (int c = 0; c < 40 && !hit; c++) begin
         tick();
         if (valid_out === 1'b1 && idx_i === 2'd2 && idx_j === 2'd1) hit = 1;
      end
      n_total++;
      if (!hit) $display("FAIL reach_beat_2_1: hit=%0d, required 1", hit);
      else n_pass++;
      rst_n = 1'b0;
      ce    = 1'b0;
      tick();
      n_total++;
      if ({busy, done, valid_out, act_vec} !== '0)
         $display("FAIL reset_mid: got %b%b%b %h, required all zero", busy, done, valid_out, act_vec);
      else n_pass++;
      rst_n = 1'b1;
      ce    = 1'b1;
      for (int c = 0; c < 20; c++) begin
         tick();
         if (valid_out !== 1'b0 || done !== 1'b0) seen = 1;
      end
      n_total++;
      if (seen) $display("FAIL reset_abort_quiet: activity seen=%0d, required 0", seen);
      else n_pass++;
      clear_model();
      run_seq(0, 0, 0);
   endtask

   task automatic test_random();
      int cref;
      for (int r = 0; r < 4; r++)
         for (int c = 0; c < 4; c++) begin
            write_elem(0, r, c, DW'($urandom));
            write_elem(1, r, c, DW'($urandom));
         end
      run_seq(0, 0, 1);
      for (int k = 0; k < 16; k++) begin
         cref = 0;
         for (int m = 0; m < 4; m++) cref += int'(ma[k/4][m]) * int'(mb[m][k%4]);
         n_total++;
         if (k >= cap_dot.size() || cap_dot[k] != cref)
            $display("FAIL product_c%0d%0d: got %0d, required %0d", k/4, k%4,
                     (k < cap_dot.size()) ? cap_dot[k] : 0, cref);
         else n_pass++;
      end
   endtask

   task automatic test_back_to_back();
      int beats = 0;
      int dones = 0;
      int t_done = -1;
      int t_first2 = -1;
      start = 1'b1;
      ce    = 1'b1;
      for (int c = 0; c < 120 && dones < 2; c++) begin
         tick();
         if (valid_out === 1'b1) begin
            n_total++;
            if (act_vec !== exp_vec(beats % 16))
               $display("FAIL b2b_beat%0d: got %h, required %h", beats, act_vec, exp_vec(beats % 16));
            else n_pass++;
            beats++;
            if (beats == 17) t_first2 = c;
         end
         if (done === 1'b1) begin
            dones++;
            if (dones == 1) t_done = c;
            if (dones == 2) start = 1'b0;
         end
      end
      start = 1'b0;
      n_total++;
      if (dones != 2 || beats != 32) $display("FAIL b2b_count: dones=%0d beats=%0d, required 2/32", dones, beats);
      else n_pass++;
      n_total++;
      if (t_first2 != t_done + 2) $display("FAIL b2b_gap: restart at %0d, required %0d", t_first2, t_done + 2);
      else n_pass++;
      tick();
      n_total++;
      if (busy !== 1'b0) $display("FAIL b2b_stop: busy=%b, required 0", busy);
      else n_pass++;
   endtask

   initial begin
      test_reset();
      test_identity();
      test_signs();
      test_ce_toggle();
      test_busy_ignore();
      test_random();
      test_back_to_back();
      test_reset_mid();
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
`default_nettype wire
